// File: rtl/mc_pkg.sv
// mc_ctrl shared encodings: opcodes, functs, states and datapath select codes.
// Also imported by the datapath ALU and the immediate extender.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2,
    ALU_LUI = 3'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'd0,
    EXT_SIGN = 2'd1,
    EXT_HIGH = 2'd2
  } ext_op_t;

  typedef enum logic [1:0] {
    RD_RT = 2'd0,
    RD_RD = 2'd1,
    RD_RA = 2'd2
  } reg_dst_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  // One-hot instruction class produced by mc_decode
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
  } inst_t;

  function automatic logic is_rtype(inst_t i);
    return i.addu | i.subu;
  endfunction

  function automatic logic is_mem(inst_t i);
    return i.lw | i.sw;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: opcode/funct to one-hot instruction class plus illegal flag.
// jal is only recognised when MC_CTRL_JAL_EN is defined.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output inst_t      inst,
  output logic       illegal
);

  // Classify the instruction; anything unmatched is illegal
  always_comb begin
    inst = '0;
    unique case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADDU) inst.addu = 1'b1;
        else if (funct == FN_SUBU) inst.subu = 1'b1;
      end
      OP_ORI: inst.ori = 1'b1;
      OP_LW:  inst.lw  = 1'b1;
      OP_SW:  inst.sw  = 1'b1;
      OP_BEQ: inst.beq = 1'b1;
      OP_LUI: inst.lui = 1'b1;
      OP_J:   inst.j   = 1'b1;
`ifdef MC_CTRL_JAL_EN
      OP_JAL: inst.jal = 1'b1;
`endif
      default: ;
    endcase
    illegal = ~|inst;
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the single-ported MIPS datapath.
// Optional jal support is enabled with MC_CTRL_JAL_EN.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_rdy,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       npc_sel,
  output logic       is_jump,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic       alu_src,
  output logic [2:0] alu_op,
  output logic [1:0] ext_op,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [1:0] wb_sel,
  output logic [2:0] state,
  output logic       illegal
);

  state_t cur;
  state_t nxt;
  inst_t  inst;
  logic   bad_op;

  logic   pc_c;
  logic   ir_c;
  logic   npc_c;
  logic   jmp_c;
  logic   rw_c;
  logic   mr_c;
  logic   mw_c;

  // alu_zero is consumed by the NPC, not by the sequencer
  logic   unused_ok;
  assign unused_ok = alu_zero;

  mc_decode u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .inst    (inst),
    .illegal (bad_op)
  );

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) cur <= S_IF;
    else      cur <= nxt;
  end

  // Next-state sequencing
  always_comb begin
    nxt = cur;
    case (cur)
      S_IF: nxt = S_ID;
      S_ID: begin
        if (bad_op)        nxt = S_TRAP;
        else if (inst.j)   nxt = S_IF;
        else if (inst.jal) nxt = S_WB;
        else               nxt = S_EX;
      end
      S_EX: begin
        if (inst.beq)          nxt = S_IF;
        else if (is_mem(inst)) nxt = S_MEM;
        else                   nxt = S_WB;
      end
      S_MEM: begin
        if (mem_rdy) nxt = inst.lw ? S_WB : S_IF;
      end
      S_WB:   nxt = S_IF;
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_IF;
    endcase
  end

  // Per-state datapath enables and selects
  always_comb begin
    pc_c    = 1'b0;
    ir_c    = 1'b0;
    npc_c   = 1'b0;
    jmp_c   = 1'b0;
    rw_c    = 1'b0;
    mr_c    = 1'b0;
    mw_c    = 1'b0;
    reg_dst = RD_RT;
    alu_src = 1'b0;
    alu_op  = ALU_ADD;
    ext_op  = EXT_ZERO;
    wb_sel  = WB_ALU;
    case (cur)
      S_IF: ir_c = 1'b1;
      S_ID: begin
        if (inst.j) begin
          jmp_c = 1'b1;
          pc_c  = 1'b1;
        end
      end
      S_EX: begin
        unique case (1'b1)
          inst.addu: alu_op = ALU_ADD;
          inst.subu: alu_op = ALU_SUB;
          inst.ori: begin
            alu_op  = ALU_OR;
            alu_src = 1'b1;
          end
          inst.lui: begin
            alu_op  = ALU_LUI;
            alu_src = 1'b1;
            ext_op  = EXT_HIGH;
          end
          inst.lw, inst.sw: begin
            alu_op  = ALU_ADD;
            alu_src = 1'b1;
            ext_op  = EXT_SIGN;
          end
          inst.beq: begin
            alu_op = ALU_SUB;
            npc_c  = 1'b1;
            pc_c   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mr_c = inst.lw;
        mw_c = inst.sw;
        pc_c = inst.sw & mem_rdy;
      end
      S_WB: begin
        rw_c = 1'b1;
        pc_c = 1'b1;
        if (is_rtype(inst)) reg_dst = RD_RD;
        if (inst.lw) wb_sel = WB_MEM;
        if (inst.jal) begin
          jmp_c   = 1'b1;
          reg_dst = RD_RA;
          wb_sel  = WB_PC4;
        end
      end
      default: ;
    endcase
  end

  // Reset forces every enable low in the same cycle
  assign pc_wr   = pc_c  & rst;
  assign ir_wr   = ir_c  & rst;
  assign npc_sel = npc_c & rst;
  assign is_jump = jmp_c & rst;
  assign reg_wr  = rw_c  & rst;
  assign mem_rd  = mr_c  & rst;
  assign mem_wr  = mw_c  & rst;

  assign state   = cur;
  assign illegal = (cur == S_TRAP);

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized instruction stream against a per-instruction
// cycle-sequence model built from the instruction timing rules.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_zero = 1'b0;
  logic       mem_rdy = 1'b0;
  logic       pc_wr, ir_wr, npc_sel, is_jump, reg_wr;
  logic [1:0] reg_dst, ext_op, wb_sel;
  logic       alu_src, mem_rd, mem_wr, illegal;
  logic [2:0] alu_op, state;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LW = 3, C_SW = 4;
  localparam int C_BEQ = 5, C_LUI = 6, C_J = 7, C_JAL = 8, C_ILL = 9;

  typedef struct packed {
    logic [2:0] st;
    logic       pc;
    logic       ir;
    logic       npc;
    logic       jmp;
    logic       rw;
    logic [1:0] rd;
    logic       as;
    logic [2:0] ao;
    logic [1:0] eo;
    logic       mr;
    logic       mw;
    logic [1:0] wb;
    logic       il;
  } ov_t;

  typedef struct {
    ov_t v;
    bit  rdy;
    bit  rstv;
  } cyc_t;

  ov_t obs;
  assign obs = {state, pc_wr, ir_wr, npc_sel, is_jump, reg_wr, reg_dst,
                alu_src, alu_op, ext_op, mem_rd, mem_wr, wb_sel, illegal};

  mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_rdy(mem_rdy),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .npc_sel(npc_sel),
    .is_jump(is_jump), .reg_wr(reg_wr), .reg_dst(reg_dst),
    .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_sel(wb_sel),
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic int classify(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h21) return C_ADDU;
      if (fn == 6'h23) return C_SUBU;
      return C_ILL;
    end
    case (op)
      6'h0d: return C_ORI;
      6'h23: return C_LW;
      6'h2b: return C_SW;
      6'h04: return C_BEQ;
      6'h0f: return C_LUI;
      6'h02: return C_J;
`ifdef MC_CTRL_JAL_EN
      6'h03: return C_JAL;
`endif
      default: return C_ILL;
    endcase
  endfunction

  // Builds the expected cycle list of one instruction, then plays it
  task automatic play(logic [5:0] op, logic [5:0] fn, int waits,
                      bit hold0, bit rst_mid);
    cyc_t q[$];
    cyc_t c;
    ov_t  e;
    int   k;
    k = classify(op, fn);
    c.rstv = 1'b1;
    c.rdy  = 1'b0;
    e = '0; e.ir = 1'b1;
    c.v = e; q.push_back(c);
    e = '0; e.st = 3'd1;
    if (k == C_J) begin e.jmp = 1'b1; e.pc = 1'b1; end
    c.v = e; q.push_back(c);
    if (k == C_ILL) begin
      e = '0; e.st = 3'd7; e.il = 1'b1;
      c.v = e;
      repeat (10) q.push_back(c);
      c.rstv = 1'b0;
      q.push_back(c);
    end else if (k == C_JAL) begin
      e = '0; e.st = 3'd4; e.rw = 1'b1; e.pc = 1'b1; e.jmp = 1'b1;
      e.rd = 2'd2; e.wb = 2'd2;
      c.v = e; q.push_back(c);
    end else if (k != C_J) begin
      e = '0; e.st = 3'd2;
      case (k)
        C_SUBU: e.ao = 3'd1;
        C_ORI: begin e.ao = 3'd2; e.as = 1'b1; end
        C_LUI: begin e.ao = 3'd3; e.as = 1'b1; e.eo = 2'd2; end
        C_LW, C_SW: begin e.as = 1'b1; e.eo = 2'd1; end
        C_BEQ: begin e.ao = 3'd1; e.npc = 1'b1; e.pc = 1'b1; end
        default: ;
      endcase
      c.v = e; q.push_back(c);
      if (k == C_LW || k == C_SW) begin
        for (int w = 0; w <= waits; w++) begin
          e = '0; e.st = 3'd3;
          if (rst_mid && w == 1) begin
            c.rstv = 1'b0; c.rdy = 1'b0; c.v = e;
            q.push_back(c);
            break;
          end
          e.mr = (k == C_LW);
          e.mw = (k == C_SW);
          c.rdy = (w == waits);
          e.pc = (k == C_SW) && (w == waits);
          c.v = e; q.push_back(c);
        end
      end
      if (!rst_mid && k != C_BEQ && k != C_SW) begin
        e = '0; e.st = 3'd4; e.rw = 1'b1; e.pc = 1'b1;
        e.rd = (k == C_ADDU || k == C_SUBU) ? 2'd1 : 2'd0;
        e.wb = (k == C_LW) ? 2'd1 : 2'd0;
        c.rdy = 1'b0; c.v = e; q.push_back(c);
      end
    end
    foreach (q[i]) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        opcode = op;
        funct  = fn;
      end
      rst      = q[i].rstv;
      alu_zero = 1'($urandom);
      if (q[i].v.st == 3'd3 || q[i].rdy) mem_rdy = q[i].rdy;
      else mem_rdy = hold0 ? 1'b0 : 1'($urandom);
      @(negedge clk);
      check($sformatf("op%h/%h c%0d", op, fn, i), 32'(obs), 32'(q[i].v));
    end
  endtask

  logic [5:0] ops [9] = '{6'h00, 6'h00, 6'h0d, 6'h23, 6'h2b,
                          6'h04, 6'h0f, 6'h02, 6'h03};
  logic [5:0] fns [2] = '{6'h21, 6'h23};

  initial begin
    ov_t z;
    logic [5:0] op, fn;
    int sel;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    z = '0;
    check("reset", 32'(obs), 32'(z));

    play(6'h0d, 6'h00, 0, 1'b1, 1'b0);
    play(6'h23, 6'h00, 3, 1'b0, 1'b0);
    play(6'h04, 6'h00, 0, 1'b0, 1'b0);
    play(6'h02, 6'h00, 0, 1'b0, 1'b0);
    play(6'h3f, 6'h00, 0, 1'b0, 1'b0);
    play(6'h2b, 6'h00, 3, 1'b0, 1'b1);
    play(6'h2b, 6'h00, 0, 1'b0, 1'b0);
    play(6'h03, 6'h00, 0, 1'b0, 1'b0);
    play(6'h00, 6'h22, 0, 1'b0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 11);
      if (sel < 9) begin
        op = ops[sel];
        fn = (sel < 2) ? fns[sel] : 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      play(op, fn, $urandom_range(0, 3), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the single-ported MIPS datapath built around `insfetch`. It sequences every instruction through fetch, decode, execute, memory and write-back states. It gates PC, IR, register-file and data-memory writes, and drives the `npc_sel`/`isJump` controls consumed by `NextPCcalculator`. It sits between the instruction register (opcode/funct source) and the datapath enables, and stalls on a data-memory ready handshake.

## Interface
Parameters:
- None. Encodings are fixed in the package.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  reset; synchronous, active-low (0 = reset)
- `opcode`  in  6  IR[31:26]; stable from the cycle after `ir_wr`
- `funct`  in  6  IR[5:0]
- `alu_zero`  in  1  ALU zero flag, sampled by the NPC during the BEQ execute cycle
- `mem_rdy`  in  1  data-memory access complete
- `pc_wr`  out  1  PC load enable
- `ir_wr`  out  1  instruction register load enable
- `npc_sel`  out  1  branch-select to NPC; 1 only in BEQ execute
- `is_jump`  out  1  jump-select to NPC
- `reg_wr`  out  1  register-file write enable
- `reg_dst`  out  2  write-address select: 0=rt, 1=rd, 2=$31
- `alu_src`  out  1  ALU B operand: 0=rt, 1=extended immediate
- `alu_op`  out  3  ALU function code, from the package
- `ext_op`  out  2  immediate extender mode: 0=zero, 1=sign, 2=high (imm<<16)
- `mem_rd`  out  1  data-memory read request
- `mem_wr`  out  1  data-memory write request
- `wb_sel`  out  2  write-back source: 0=ALU, 1=memory, 2=PC+4
- `state`  out  3  current state, for debug
- `illegal`  out  1  sticky trap flag

## Operation
- Supported instructions: addu (R, funct 100001), subu (R, funct 100011), ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010.
- States: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4, S_TRAP=7.
- S_IF: `ir_wr`=1. Always advances to S_ID.
- S_ID: decode.
  - j: `is_jump`=1, `pc_wr`=1, next S_IF.
  - Unknown opcode, or opcode 0 with an unknown funct: next S_TRAP.
  - Otherwise: next S_EX.
- S_EX: drives `alu_op`, `alu_src` and `ext_op` per instruction.
  - beq: `alu_op`=SUB, `npc_sel`=1, `pc_wr`=1, next S_IF. The NPC resolves taken/not-taken from `alu_zero`.
  - lw/sw: next S_MEM, `ext_op`=sign, `alu_op`=ADD.
  - addu/subu/ori/lui: next S_WB. ori uses zero extension; lui uses high extension with `alu_op`=LUI.
- S_MEM: assert `mem_rd` (lw) or `mem_wr` (sw) and hold it every cycle until `mem_rdy`=1.
  - If `mem_rdy`=0: remain in S_MEM. No timeout.
  - On `mem_rdy`=1: lw goes to S_WB. sw asserts `pc_wr`=1 and goes to S_IF.
- S_WB: `reg_wr`=1, `pc_wr`=1, next S_IF.
  - `reg_dst`=1 for R-type, 0 for I-type.
  - `wb_sel`=1 for lw, 0 otherwise.
- S_TRAP: `illegal`=1. All enables are 0. Only reset exits this state.
- In non-listed states every enable is 0 and every select is 0.

## Timing
- Outputs are combinational from the `state` register plus `opcode`/`funct`. There is no output register.
- Instruction latency in cycles, with zero memory wait:
  - j: 2
  - beq: 3
  - sw: 4
  - R-type, ori, lui: 4
  - lw: 5
- Each memory wait cycle adds 1.
- `pc_wr` is asserted exactly once per retired instruction, on its final cycle. The PC changes on the edge ending that cycle.
- Reset:
  - `rst`=0 sampled at an edge forces `state`=S_IF and clears `illegal`.
  - While `rst`=0, all enables (`pc_wr`, `ir_wr`, `reg_wr`, `mem_rd`, `mem_wr`, `npc_sel`, `is_jump`) are forced to 0.
  - The first cycle after release is S_IF with `ir_wr`=1.
- Reset during S_MEM abandons the access. The request drops in the same cycle `rst` goes low.
- `mem_rdy` is ignored outside S_MEM.
- If `mem_rdy`=1 in the first S_MEM cycle, the state advances with no stall.

## Configuration
- `MC_CTRL_JAL_EN` defined:
  - jal (000011) is legal.
  - Sequence: S_ID goes to S_WB, with `is_jump`=1 and `pc_wr`=1 in S_WB.
  - In S_WB: `reg_wr`=1, `reg_dst`=2, `wb_sel`=2. Total 3 cycles.
- `MC_CTRL_JAL_EN` undefined: opcode 000011 is illegal and leads to S_TRAP.

## Structure
- Package `mc_pkg` holds:
  - opcode and funct constants;
  - the state encoding;
  - ALU_OP codes: ADD=0, SUB=1, OR=2, LUI=3;
  - EXT_OP, REG_DST and WB_SEL codes.
- The datapath ALU and extender import the same package.
- One sub-module, `mc_decode`: combinational opcode/funct to instruction-class one-hot. It also produces the `illegal` decision.
- The FSM and output logic stay in `mc_ctrl`.

## Test plan
- Reset, then ori (opcode 001101), `mem_rdy` held 0:
  - `state` sequence 0,1,2,4,0;
  - `pc_wr` high only in the S_WB cycle;
  - `ext_op`=0, `alu_op`=2.
- lw with `mem_rdy` low for 3 cycles:
  - `mem_rd` high for 4 consecutive cycles;
  - `reg_wr`=1 with `wb_sel`=1 on cycle 8;
  - 8 cycles total.
- beq:
  - `npc_sel`=1 and `pc_wr`=1 in the single S_EX cycle;
  - `reg_wr` never asserted;
  - back to S_IF on the 4th cycle.
- j: `is_jump`=1 and `pc_wr`=1 in S_ID; 2 cycles per instruction.
- Opcode 111111:
  - S_TRAP with `illegal`=1;
  - all enables 0 for 10 cycles;
  - `rst`=0 for one cycle returns to S_IF with `illegal`=0.
- sw with `rst` driven low during the second S_MEM cycle:
  - `mem_wr` drops in that cycle;
  - no `pc_wr`;
  - S_IF with `ir_wr`=1 after release.
